// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: opcodes, fixed register
// numbers, FSM encoding and the decode result type.
package wb_arbiter_pkg;

  localparam logic [4:0] OP_RTYPE   = 5'b00000;
  localparam logic [4:0] OP_ADDI    = 5'b00101;
  localparam logic [4:0] OP_LW      = 5'b01000;
  localparam logic [4:0] OP_SETX    = 5'b10101;

  localparam logic [4:0] REG_LINK   = 5'd31;
  localparam logic [4:0] REG_STATUS = 5'd30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } wb_state_e;

  typedef enum logic [1:0] {
    SEL_O    = 2'd0,
    SEL_D    = 2'd1,
    SEL_PC   = 2'd2,
    SEL_SETX = 2'd3
  } wb_sel_e;

  typedef struct packed {
    logic    we;
    logic [4:0] rd;
    wb_sel_e sel;
  } wb_dec_t;

  function automatic logic [31:0] setx_word(input logic [26:0] imm);
    return {5'b00000, imm};
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: MEM/WB latch outputs, mult/div completion handshake and the
// register-file write port.
interface wb_arbiter_if;
  logic        valid_in;
  logic [31:0] o_in;
  logic [31:0] d_in;
  logic [31:0] ir_in;
  logic [31:0] pc_jal_in;
  logic        jal_in;
  logic        exception_in;
  logic        md_ready;
  logic [31:0] md_result;
  logic [4:0]  md_rd;
  logic        md_ack;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        stall_out;

  modport slave (
    input  valid_in, o_in, d_in, ir_in, pc_jal_in, jal_in, exception_in,
    input  md_ready, md_result, md_rd,
    output md_ack, ctrl_writeEnable, ctrl_writeReg, data_writeReg, stall_out
  );

  modport master (
    output valid_in, o_in, d_in, ir_in, pc_jal_in, jal_in, exception_in,
    output md_ready, md_result, md_rd,
    input  md_ack, ctrl_writeEnable, ctrl_writeReg, data_writeReg, stall_out
  );
endinterface

// File: rtl/wb_arbiter_decode.sv
// Combinational writeback decode: instruction fields -> write enable,
// destination register and data source. Shared with forwarding logic.
module wb_decode
  import wb_arbiter_pkg::*;
(
  input  logic [4:0] opcode_i,
  input  logic [4:0] rd_i,
  input  logic       jal_i,
  input  logic       exception_i,
  output wb_dec_t    dec_o
);

  // Exception beats jal beats the opcode table.
  always_comb begin
    dec_o = '{we: 1'b0, rd: 5'd0, sel: SEL_O};
    if (exception_i) begin
      dec_o = '{we: 1'b1, rd: REG_STATUS, sel: SEL_O};
    end else if (jal_i) begin
      dec_o = '{we: 1'b1, rd: REG_LINK, sel: SEL_PC};
    end else begin
      case (opcode_i)
        OP_SETX:          dec_o = '{we: 1'b1, rd: REG_STATUS, sel: SEL_SETX};
        OP_LW:            dec_o = '{we: 1'b1, rd: rd_i, sel: SEL_D};
        OP_RTYPE, OP_ADDI: dec_o = '{we: 1'b1, rd: rd_i, sel: SEL_O};
        default:          dec_o = '{we: 1'b0, rd: 5'd0, sel: SEL_O};
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: arbitrates the register-file write port between the
// MEM/WB pipeline and late mult/div results, with a starvation drain.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned MD_WAIT_MAX = 2
) (
  input  logic          clock,
  input  logic          reset,
  wb_arbiter_if.slave   bus
);

  localparam logic [2:0] WAIT_MAX = MD_WAIT_MAX[2:0];

  wb_state_e   state_q;
  logic [2:0]  wait_cnt_q;
  logic        stall_q;

  wb_dec_t     dec_s;
  logic        pipe_we_s;
  logic        in_force_s;
  logic        md_win_s;
  logic [31:0] pipe_data_s;
  logic        we_s;
  logic [4:0]  reg_s;
  logic [31:0] data_s;

  wb_decode u_decode (
    .opcode_i    (bus.ir_in[31:27]),
    .rd_i        (bus.ir_in[26:22]),
    .jal_i       (bus.jal_in),
    .exception_i (bus.exception_in),
    .dec_o       (dec_s)
  );

  assign pipe_we_s  = bus.valid_in & dec_s.we & (dec_s.rd != 5'd0);
  assign in_force_s = (state_q == ST_FORCE);
  // In FORCE the latch is frozen, so the md result takes the port regardless.
  assign md_win_s   = bus.md_ready & (in_force_s | ~pipe_we_s);

  // Pipeline write-data source select.
  always_comb begin
    pipe_data_s = 32'd0;
    case (dec_s.sel)
      SEL_O:    pipe_data_s = bus.o_in;
      SEL_D:    pipe_data_s = bus.d_in;
      SEL_PC:   pipe_data_s = bus.pc_jal_in;
      SEL_SETX: pipe_data_s = setx_word(bus.ir_in[26:0]);
      default:  pipe_data_s = bus.o_in;
    endcase
  end

  // Write-port mux; address and data read zero whenever nothing is written.
  always_comb begin
    we_s   = 1'b0;
    reg_s  = 5'd0;
    data_s = 32'd0;
    if (md_win_s) begin
      if (bus.md_rd != 5'd0) begin
        we_s   = 1'b1;
        reg_s  = bus.md_rd;
        data_s = bus.md_result;
      end else begin
        we_s   = 1'b0;
      end
    end else if (pipe_we_s && !in_force_s) begin
      we_s   = 1'b1;
      reg_s  = dec_s.rd;
      data_s = pipe_data_s;
    end else begin
      we_s   = 1'b0;
    end
  end

  assign bus.ctrl_writeEnable = we_s;
  assign bus.ctrl_writeReg    = reg_s;
  assign bus.data_writeReg    = data_s;
  assign bus.md_ack           = md_win_s;
  assign bus.stall_out        = stall_q;

  // Starvation FSM: counts lost arbitrations and schedules a one-cycle drain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 3'd0;
      stall_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_PEND: begin
          if (!bus.md_ready || !pipe_we_s) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 3'd0;
            stall_q    <= 1'b0;
          end else if (state_q == ST_PEND && wait_cnt_q == WAIT_MAX) begin
            state_q    <= ST_FORCE;
            wait_cnt_q <= wait_cnt_q;
            stall_q    <= 1'b1;
          end else begin
            state_q    <= ST_PEND;
            wait_cnt_q <= wait_cnt_q + 3'd1;
            stall_q    <= 1'b0;
          end
        end
        ST_FORCE: begin
          state_q    <= ST_IDLE;
          wait_cnt_q <= 3'd0;
          stall_q    <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          wait_cnt_q <= 3'd0;
          stall_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic compared against a loss-counting reference model.
module tb_wb_arbiter;

  localparam int WMAX = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  wb_arbiter_if bus ();

  wb_arbiter #(.MD_WAIT_MAX(WMAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: consecutive losses of a pending md result, and a drain flag.
  int lost    = 0;
  bit forcing = 1'b0;
  bit last_ack;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [21:0] low);
    return {op, rd, low};
  endfunction

  task automatic drive(input bit v, input logic [31:0] ir, input logic [31:0] o, input logic [31:0] d,
                       input logic [31:0] pc, input bit jal, input bit exc,
                       input bit mdr, input logic [4:0] mdrd, input logic [31:0] mdres);
    bus.valid_in     = v;
    bus.ir_in        = ir;
    bus.o_in         = o;
    bus.d_in         = d;
    bus.pc_jal_in    = pc;
    bus.jal_in       = jal;
    bus.exception_in = exc;
    bus.md_ready     = mdr;
    bus.md_rd        = mdrd;
    bus.md_result    = mdres;
  endtask

  // Compare all outputs against the model, then advance the model across the next edge.
  task automatic step_check(input string tag);
    bit          has;
    logic [4:0]  tgt;
    logic [31:0] pdat;
    bit          pw, md_wins, e_we, e_ack;
    logic [4:0]  e_reg;
    logic [31:0] e_dat;
    logic [4:0]  op;
    has = 1'b0; tgt = 5'd0; pdat = 32'd0;
    op  = bus.ir_in[31:27];
    if (bus.valid_in) begin
      if (bus.exception_in) begin has = 1'b1; tgt = 5'd30; pdat = bus.o_in; end
      else if (bus.jal_in) begin has = 1'b1; tgt = 5'd31; pdat = bus.pc_jal_in; end
      else if (op == 5'd21) begin has = 1'b1; tgt = 5'd30; pdat = bus.ir_in & 32'h07FF_FFFF; end
      else if (op == 5'd8) begin has = 1'b1; tgt = bus.ir_in[26:22]; pdat = bus.d_in; end
      else if (op == 5'd0 || op == 5'd5) begin has = 1'b1; tgt = bus.ir_in[26:22]; pdat = bus.o_in; end
    end
    pw = has && (tgt != 5'd0);
    md_wins = bus.md_ready && (forcing || !pw);
    e_we = 1'b0; e_reg = 5'd0; e_dat = 32'd0; e_ack = md_wins;
    if (md_wins) begin
      if (bus.md_rd != 5'd0) begin e_we = 1'b1; e_reg = bus.md_rd; e_dat = bus.md_result; end
    end else if (pw && !forcing) begin
      e_we = 1'b1; e_reg = tgt; e_dat = pdat;
    end
    check_eq({tag, ".we"},    32'(bus.ctrl_writeEnable), 32'(e_we));
    check_eq({tag, ".reg"},   32'(bus.ctrl_writeReg),    32'(e_reg));
    check_eq({tag, ".data"},  bus.data_writeReg,         e_dat);
    check_eq({tag, ".ack"},   32'(bus.md_ack),           32'(e_ack));
    check_eq({tag, ".stall"}, 32'(bus.stall_out),        32'(forcing));
    last_ack = e_ack;
    if (forcing) begin
      forcing = 1'b0;
      lost    = 0;
    end else if (bus.md_ready && pw) begin
      lost++;
      if (lost == WMAX + 1) forcing = 1'b1;
    end else begin
      lost = 0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  logic [4:0] ops [6] = '{5'd0, 5'd5, 5'd8, 5'd21, 5'd7, 5'd31};
  bit          md_pend;
  logic [4:0]  md_rd_r;
  logic [31:0] md_res_r;

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    #12;
    check_eq("rst.stall", 32'(bus.stall_out), 32'd0);
    check_eq("rst.ack",   32'(bus.md_ack), 32'd0);
    check_eq("rst.we",    32'(bus.ctrl_writeEnable), 32'd0);
    next_cycle();
    reset = 1'b0;

    // lw r5
    drive(1'b1, mk(5'd8, 5'd5, 22'd0), 32'd0, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    check_eq("lw.reg",  32'(bus.ctrl_writeReg), 32'd5);
    check_eq("lw.data", bus.data_writeReg, 32'hDEADBEEF);
    step_check("lw");
    next_cycle();

    // exception beats jal
    drive(1'b1, mk(5'd0, 5'd3, 22'd0), 32'd3, 32'd0, 32'd77, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    check_eq("exc.reg",  32'(bus.ctrl_writeReg), 32'd30);
    check_eq("exc.data", bus.data_writeReg, 32'd3);
    step_check("exc");
    next_cycle();

    // add to r0 leaves the port to the md result
    drive(1'b1, mk(5'd0, 5'd0, 22'd0), 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'd42);
    @(negedge clock);
    check_eq("mdr0.reg",  32'(bus.ctrl_writeReg), 32'd7);
    check_eq("mdr0.data", bus.data_writeReg, 32'd42);
    check_eq("mdr0.ack",  32'(bus.md_ack), 32'd1);
    step_check("mdr0");
    next_cycle();

    // starvation: 3 losses then forced drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mk(5'd5, 5'd4, 22'd0), 32'h100 + 32'(i), 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h55);
      @(negedge clock);
      check_eq($sformatf("starve%0d.stall", i), 32'(bus.stall_out), (i == 3) ? 32'd1 : 32'd0);
      check_eq($sformatf("starve%0d.reg", i), 32'(bus.ctrl_writeReg), (i == 3) ? 32'd9 : 32'd4);
      step_check($sformatf("starve%0d", i));
      next_cycle();
    end
    drive(1'b1, mk(5'd5, 5'd4, 22'd0), 32'h200, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    check_eq("post_force.stall", 32'(bus.stall_out), 32'd0);
    step_check("post_force");
    next_cycle();

    // reset during FORCE
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(5'd0, 5'd6, 22'd0), 32'h300, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd12, 32'hAB);
      @(negedge clock);
      step_check($sformatf("prerst%0d", i));
      next_cycle();
    end
    check_eq("force.stall", 32'(bus.stall_out), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rstforce.stall", 32'(bus.stall_out), 32'd0);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd12, 32'hAB);
    next_cycle();
    reset   = 1'b0;
    lost    = 0;
    forcing = 1'b0;
    @(negedge clock);
    check_eq("retry.ack", 32'(bus.md_ack), 32'd1);
    step_check("retry");
    next_cycle();

    // setx and an unrecognised opcode
    drive(1'b1, {5'b10101, 27'h1234}, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    check_eq("setx.data", bus.data_writeReg, 32'h0000_1234);
    step_check("setx");
    next_cycle();
    drive(1'b1, mk(5'b00111, 5'd3, 22'd0), 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clock);
    check_eq("sw.we", 32'(bus.ctrl_writeEnable), 32'd0);
    step_check("sw");
    next_cycle();

    // random traffic; an md result is held until the model says it was acked
    md_pend = 1'b0; md_rd_r = 5'd0; md_res_r = 32'd0;
    for (int c = 0; c < 500; c++) begin
      if (!md_pend && $urandom_range(0, 9) < 4) begin
        md_pend  = 1'b1;
        md_rd_r  = 5'($urandom_range(0, 31));
        md_res_r = $urandom;
      end
      drive($urandom_range(0, 9) < 9,
            mk(ops[$urandom_range(0, 5)], 5'($urandom_range(0, 31)), 22'($urandom)),
            $urandom, $urandom, $urandom,
            $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
            md_pend, md_pend ? md_rd_r : 5'd0, md_pend ? md_res_r : 32'd0);
      @(negedge clock);
      step_check($sformatf("rnd%0d", c));
      if (last_ack) md_pend = 1'b0;
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
